// File: rtl/serial_adder_subtracter.sv
// -----------------------------------------------------------------------------
// serial_adder_subtracter
//
// Multi-cycle two's-complement adder/subtracter. It handles DIGIT bits per
// clock and takes N = WIDTH/DIGIT cycles per operation. A start/done handshake
// controls it. An internal accumulator holds each result so that the next
// operation can chain from it. For plain add and subtract, the results and
// flags match a single-cycle WIDTH-bit adder/subtracter bit-for-bit.
//
// Parameters:
//   WIDTH    operand/result width in bits (>= 2)
//   DIGIT    bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all state
//   start    request; accepted on a rising edge only while idle or done
//   a, b     signed operands, latched when start is accepted
//   mode     00 a+b, 01 a-b, 10 acc+b, 11 acc-b; latched at accept
//   busy     high while an operation is in progress
//   done     one-cycle pulse; sum/carry/overflow are valid
//   sum      signed result, held until the next completion
//   carry    carry-out of the MSB (subtract: 1 = no borrow)
//   overflow signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_subtracter #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  // The counter keeps at least one bit so that the N == 1 case stays legal.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] x_q,       x_d;      // operand X, shifted right one digit per cycle
  logic [WIDTH-1:0] y_q,       y_d;      // operand Y (b or ~b), shifted likewise
  logic [WIDTH-1:0] res_q,     res_d;    // result digits, shifted in from the top
  logic [CW-1:0]    cnt_q,     cnt_d;    // index of the digit being processed
  logic             cin_q,     cin_d;    // running carry between digits
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             carry_q,   carry_d;
  logic             ovf_q,     ovf_d;

  // ---------------------------------------------------------------------------
  // Digit adder: ripple across DIGIT bits. It also records the carry into the
  // top bit of the digit. On the last digit, that bit is the MSB of the word,
  // so this carry is the value the overflow flag needs.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0]       dsum;
  logic                   dcout;
  logic                   dc_top;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_shift;

  always_comb begin : digit_add
    logic c;
    c      = cin_q;
    dc_top = 1'b0;
    dsum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) dc_top = c;
      dsum[i] = x_q[i] ^ y_q[i] ^ c;
      c       = (x_q[i] & y_q[i]) | (x_q[i] & c) | (y_q[i] & c);
    end
    dcout = c;
  end

  // The new digit enters at the top. After N digits, digit 0 has reached the
  // bottom. The concatenation keeps the slice legal when DIGIT == WIDTH.
  assign res_cat   = {dsum, res_q};
  assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract is X + ~b + 1. The +1 enters as the initial carry.
          x_d     = mode[1] ? acc_q : a;
          y_d     = mode[0] ? ~b : b;
          cin_d   = mode[0];
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        x_d   = x_q >> DIGIT;
        y_d   = y_q >> DIGIT;
        res_d = res_shift;
        cin_d = dcout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIGIT) begin
          sum_d   = res_shift;
          carry_d = dcout;
          ovf_d   = dcout ^ dc_top;
          acc_d   = res_shift;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // here is a small flop that a reset can clear; there is no memory array to
  // exclude from reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_subtracter.sv
// -----------------------------------------------------------------------------
// Testbench for serial_adder_subtracter. Unit 0 is built with DIGIT=1 and
// unit 1 with DIGIT=4, both with WIDTH=8. Expected results come from signed
// integer arithmetic and a per-unit accumulator model.
// -----------------------------------------------------------------------------
module tb_serial_adder_subtracter;

  logic       clk;
  logic       reset;
  logic       start_s    [2];
  logic [7:0] a_s        [2];
  logic [7:0] b_s        [2];
  logic [1:0] mode_s     [2];
  logic       busy_s     [2];
  logic       done_s     [2];
  logic [7:0] sum_s      [2];
  logic       carry_s    [2];
  logic       overflow_s [2];

  logic [7:0] acc_m [2];
  int total = 0;
  int bad   = 0;

  serial_adder_subtracter #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
    .mode(mode_s[0]), .busy(busy_s[0]), .done(done_s[0]), .sum(sum_s[0]),
    .carry(carry_s[0]), .overflow(overflow_s[0])
  );

  serial_adder_subtracter #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
    .mode(mode_s[1]), .busy(busy_s[1]), .done(done_s[1]), .sum(sum_s[1]),
    .carry(carry_s[1]), .overflow(overflow_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation on unit u and checks latency, busy length, the result
  // flags, the one-cycle done pulse and that the result is held afterwards.
  // With scramble set, the task toggles start and the inputs while the unit
  // is in RUN.
  task automatic do_op(input int u, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [1:0] tm, input bit scramble);
    int         n, edges, busy_n, sx, sy, r;
    bit         got_done, ec, eo;
    logic [7:0] x, es;
    n  = (u == 0) ? 8 : 2;
    x  = tm[1] ? acc_m[u] : ta;
    sx = int'($signed(x));
    sy = int'($signed(tb_v));
    r  = tm[0] ? sx - sy : sx + sy;
    es = r[7:0];
    eo = (r > 127) || (r < -128);
    ec = tm[0] ? (x >= tb_v) : ((int'(x) + int'(tb_v)) > 255);

    @(negedge clk);
    a_s[u] = ta; b_s[u] = tb_v; mode_s[u] = tm; start_s[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[u] = 1'b0;
    edges = 1; busy_n = 0; got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_s[u]) begin
        got_done = 1'b1;
        break;
      end
      if (busy_s[u]) busy_n++;
      if (scramble) begin
        start_s[u] = 1'($urandom);
        a_s[u]     = 8'($urandom);
        b_s[u]     = 8'($urandom);
        mode_s[u]  = 2'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start_s[u] = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    if (!got_done) return;
    check("latency",   32'(edges),         32'(n + 1));
    check("busy_len",  32'(busy_n),        32'(n));
    check("busy_low",  32'(busy_s[u]),     32'd0);
    check("sum",       32'(sum_s[u]),      32'(es));
    check("carry",     32'(carry_s[u]),    32'(ec));
    check("overflow",  32'(overflow_s[u]), 32'(eo));
    acc_m[u] = es;
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 32'(done_s[u]), 32'd0);
    check("idle_busy",  32'(busy_s[u]), 32'd0);
    check("sum_held",   32'(sum_s[u]),  32'(es));
  endtask

  initial begin
    int ndone, last;
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; a_s[u] = '0; b_s[u] = '0; mode_s[u] = '0; acc_m[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_busy", 32'(busy_s[u]),     32'd0);
      check("rst_done", 32'(done_s[u]),     32'd0);
      check("rst_sum",  32'(sum_s[u]),      32'd0);
      check("rst_cy",   32'(carry_s[u]),    32'd0);
      check("rst_ov",   32'(overflow_s[u]), 32'd0);
    end
    reset = 1'b0;

    // Directed cases on unit 0 (DIGIT=1)
    do_op(0, 8'd3,   8'd4,   2'b01, 1'b0);
    do_op(0, 8'd127, 8'd127, 2'b00, 1'b0);
    do_op(0, 8'd127, 8'd127, 2'b01, 1'b0);
    do_op(0, 8'd127, 8'd0,   2'b00, 1'b0);
    do_op(0, 8'd55,  8'd1,   2'b10, 1'b0);
    do_op(0, 8'd55,  8'd1,   2'b11, 1'b0);
    do_op(0, 8'd40,  8'd87,  2'b01, 1'b1);

    // Directed cases on unit 1 (DIGIT=4)
    do_op(1, 8'd0, 8'd127, 2'b01, 1'b0);

    // Back-to-back on unit 1: start held high gives one done every 3 cycles.
    @(negedge clk);
    a_s[1] = 8'd0; b_s[1] = 8'd127; mode_s[1] = 2'b01; start_s[1] = 1'b1;
    ndone = 0; last = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s[1]) begin
        ndone++;
        check("b2b_gap", 32'(e - last), 32'd3);
        check("b2b_sum", 32'(sum_s[1]), 32'h81);
        last = e;
      end
    end
    start_s[1] = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    acc_m[1] = 8'h81;
    repeat (2) @(posedge clk);

    // Reset asserted four cycles into an operation on unit 0
    @(negedge clk);
    a_s[0] = 8'd5; b_s[0] = 8'd9; mode_s[0] = 2'b00; start_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy_s[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy_s[0]),     32'd0);
    check("abort_done", 32'(done_s[0]),     32'd0);
    check("abort_sum",  32'(sum_s[0]),      32'd0);
    check("abort_cy",   32'(carry_s[0]),    32'd0);
    check("abort_ov",   32'(overflow_s[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc_m[0] = '0;
    acc_m[1] = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done_s[0]), 32'd0);
    end
    // Modes 1x read the accumulator, so these results show it was cleared.
    do_op(0, 8'h55, 8'd23, 2'b10, 1'b0);
    do_op(1, 8'h55, 8'd9,  2'b11, 1'b0);

    // Randomized operations on both units
    for (int i = 0; i < 30; i++) begin
      for (int u = 0; u < 2; u++) begin
        do_op(u, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_subtracter.md
# serial_adder_subtracter

Parametrised, multi-cycle successor to the team's 8-bit combinational adder/subtracter. Processes two's-complement operands DIGIT bits per clock over WIDTH/DIGIT cycles, with a start/done handshake and an internal accumulator mode that chains results. Sits in the datapath where area matters more than single-cycle latency; results and flags match the combinational block bit-for-bit for plain add/subtract.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled on rising clk only when idle/done
- a  input  WIDTH  signed operand A, latched at accepted start
- b  input  WIDTH  signed operand B, latched at accepted start
- mode  input  2  00 a+b, 01 a−b, 10 acc+b, 11 acc−b; latched at accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid
- sum  output  WIDTH  signed result, held until next completion
- carry  output  1  carry-out of MSB (for subtract: 1 = no borrow)
- overflow  output  1  signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch operand X (a, or acc for modes 1x), Y (b or ~b), mode; digit counter=0; carry-in = mode[0]; → RUN.
- RUN: each cycle add digit k of X and Y plus running carry; shift result digit into result register; counter increments. After digit N−1 (N=WIDTH/DIGIT): write sum, carry, overflow; acc ← sum; → DONE.
- DONE: done=1 for exactly this cycle. start=1 here is accepted as in IDLE (back-to-back, → RUN); otherwise → IDLE.
- start while in RUN: ignored, no effect on in-flight operation.
- Arithmetic: subtract is X + ~b + 1. carry = carry-out of bit WIDTH−1. overflow = carry into MSB XOR carry out of MSB. sum is WIDTH bits, wraps modulo 2^WIDTH.
- Accumulator: WIDTH-bit register, updated only at completion of any mode; reset to 0. Modes 1x use acc value at the start cycle; a is ignored.
- a/b/mode may change freely after accept; only latched copies are used.

## Timing
- Reset values: busy=0, done=0, sum=0, carry=0, overflow=0, acc=0, state IDLE.
- Reset asserted mid-RUN: immediate abort, all outputs to reset values, no done pulse; operation is lost.
- Start accepted at edge E0 → busy=1 from after E0; N RUN edges E1..EN; sum/carry/overflow update at EN; busy=0 and done=1 after EN; done falls after EN+1.
- Latency start→done: N+1 edges (WIDTH=8, DIGIT=1: 9; DIGIT=4: 3).
- Back-to-back: start held high gives one result every N+1 cycles.
- sum/carry/overflow stable from done until the next completion (not cleared on new start).

## Test plan
- WIDTH=8, DIGIT=1: a=3, b=4, mode=01 → done 9 edges after start; sum=8'hFF (−1), carry=0, overflow=0; busy high for exactly 8 cycles.
- a=127, b=127, mode=00 → sum=8'hFE, carry=0, overflow=1; then mode=01 same operands → sum=0, carry=1, overflow=0.
- Accumulate chain: a=127, b=0, mode=00 (sum 127); then b=1, mode=10 → sum=8'h80 (−128), overflow=1; then b=1, mode=11 → sum=8'h7F, carry=1, overflow=1.
- a=40, b=87, mode=01 → sum=8'hD1 (−47), carry=0, overflow=0; toggle start and change a/b during RUN → result unchanged, no extra done.
- DIGIT=4 (N=2): a=0, b=127, mode=01 → done 3 edges after start, sum=8'h81, carry=0, overflow=0; start held high → done every 3 cycles.
- Assert reset 4 cycles into an operation → busy, done, sum, carry, overflow, acc all 0 immediately; no done pulse; next start runs normally with acc=0.
